// File: rtl/bit_serial_adder_ctrl_pkg.sv
// bit_serial_adder_ctrl_pkg: shared state encoding and counter sizing for the bit-serial adder.
package bit_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/FA_df.sv
// FA_df: single-bit dataflow full adder cell.
module FA_df (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// bit_serial_adder_ctrl: adds or subtracts two WIDTH-bit operands LSB first through one
// full adder cell, one bit per clock, behind a start/done parallel interface.
module bit_serial_adder_ctrl
    import bit_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, sum_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q;
    logic             cell_s, cell_c;

    FA_df u_fa (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (carry_q),
        .s   (cell_s),
        .c   (cell_c)
    );

    // The final sum bit completes the word directly, so res_q only needs WIDTH-1 bits.
    assign res_d = {cell_s, res_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sa_q    <= op_a;
                    sb_q    <= sub ? ~op_b : op_b;
                    carry_q <= sub ? 1'b1 : cin;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= cell_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= res_d;
                        cout_q  <= cell_c;
                        ovf_q   <= carry_q ^ cell_c;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb_bit_serial_adder_ctrl: scoreboard bench; the driver queues expected results from a
// signed/unsigned arithmetic model and an independent monitor checks each done pulse.
module tb_bit_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow judged by range of the true result.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic s);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = ua - (a[W-1] ? (1 << W) : 0);
        int sb = ub - (b[W-1] ? (1 << W) : 0);
        int ur = s ? (ua - ub) : (ua + ub + int'(ci));
        int sr = s ? (sa - sb) : (sa + sb + int'(ci));
        e.s = W'(ur);
        e.c = s ? (ua >= ub) : (ur >= (1 << W));
        e.o = (sr < -(1 << (W - 1))) || (sr >= (1 << (W - 1)));
        e.cyc = 0;
        return e;
    endfunction

    // Waits for idle while scribbling on the inputs (including start) to prove they are ignored.
    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            start = $urandom_range(0, 1);
            sub   = $urandom_range(0, 1);
            cin   = $urandom_range(0, 1);
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (busy) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", t);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = ci;
        sub   = s;
        @(posedge clk);
        #1;
        e = model(a, b, ci, s);
        e.cyc = cyc;
        q.push_back(e);
        check("busy_rise", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compares each done against the scoreboard, checks pulse width, latency,
    // busy duration and that results hold steady between operations.
    initial begin
        logic [W-1:0] h_s = '0;
        logic         h_c = 1'b0, h_o = 1'b0, prev_done = 1'b0;
        int           bcnt = 0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                h_s = '0; h_c = 1'b0; h_o = 1'b0; prev_done = 1'b0; bcnt = 0;
            end else begin
                if (busy) bcnt++;
                else if (bcnt != 0) begin
                    check("busy_len", 64'(bcnt), 64'(W + 1));
                    bcnt = 0;
                end
                if (done) begin
                    check("done_pulse", prev_done, 1'b0);
                    check("busy_at_done", busy, 1'b1);
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: got done with empty scoreboard sum=0x%0h", sum);
                    end else begin
                        e = q.pop_front();
                        check("sum", sum, e.s);
                        check("cout", cout, e.c);
                        check("ovf", ovf, e.o);
                        check("latency", 64'(cyc - e.cyc), 64'(W));
                    end
                    h_s = sum; h_c = cout; h_o = ovf;
                end else begin
                    check("hold", {sum, cout, ovf}, {h_s, h_c, h_o});
                end
                prev_done = done;
            end
        end
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out", {sum, cout, ovf}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h35, 8'h4A, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0);
        do_op(8'h10, 8'h20, 1'b0, 1'b1);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b1);

        // A start while busy must be dropped; only the first operation completes.
        do_op(8'h01, 8'h01, 1'b0, 1'b0);
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        do_op(8'hAA, 8'h55, 1'b0, 1'b0);

        // Reset in the middle of RUN aborts with no pending done.
        do_op(8'h35, 8'h4A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_out", {sum, cout, ovf}, '0);
        q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op(8'h35, 8'h4A, 1'b0, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                wait_idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d results never arrived", q.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder_ctrl.md
Name: bit_serial_adder_ctrl

Overview:
- Sequences one single-bit dataflow full adder cell to add or subtract two WIDTH-bit operands, LSB first, one bit per clock.
- Used where area matters more than latency, for example in configuration-path arithmetic and counters in slow control logic.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- Exposes a parallel-in, parallel-out interface to the rest of the design.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a - b); sampled with start.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while an operation is in progress (RUN and DONE).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry-out of MSB. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter, shift registers and carry FF all cleared.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge E0: load shift_a=op_a.
  - Load shift_b=op_b, or ~op_b when sub=1.
  - Load carry FF = cin (add) or 1 (sub).
  - Clear counter and go to RUN; busy rises after E0.
- RUN:
  - Cell inputs are a=shift_a[0], b=shift_b[0], cin=carry FF.
  - Each edge: shift_a and shift_b shift right by 1.
  - Each edge: the cell sum bit enters the result register at the MSB and the result shifts right, so after WIDTH edges bit 0 is the first-computed bit.
  - Each edge: carry FF <= cell carry, and counter increments.
  - On the edge where counter == WIDTH-1, capture carry FF as carry_into_msb (before the update) and go to DONE.
- RUN ends at edge E(WIDTH). Entering DONE updates sum, cout=final carry and ovf=carry_into_msb XOR final carry.
- DONE:
  - done=1 for exactly one cycle, asserted between E(WIDTH) and E(WIDTH+1); busy=1.
  - Next edge goes to IDLE; done=0, busy=0.
- Latency: start edge to first done-high cycle is WIDTH edges. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored. No queuing and no error flag.
- Operand or control input changes during RUN have no effect; they are sampled only at acceptance.
- sum, cout and ovf change only on the transition into DONE and on reset. Between operations they hold the last result.
- Reset mid-RUN aborts the operation, clears all outputs, and leaves no pending done.
- The counter is $clog2(WIDTH) bits wide, with no wrap inside an operation.

Decomposition:
- Shared package holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - localparam CNT_W = $clog2(WIDTH).
- One natural sub-module: the existing single-bit dataflow full adder cell FA_df (a, b, cin -> s, c), instantiated once.
- No other hierarchy.

Test Plan (WIDTH=8):
- Add: op_a=0x35, op_b=0x4A, cin=0, sub=0 -> done at 8 edges after start; sum=0x7F, cout=0, ovf=0; busy high 9 cycles.
- Carry wrap: 0xFF + 0x01 with cin=0 -> sum=0x00, cout=1, ovf=0. Then 0xFF + 0x00 with cin=1 -> sum=0x00, cout=1.
- Subtract and overflow:
  - sub=1, 0x10 - 0x20 -> sum=0xF0, cout=0 (borrow), ovf=0.
  - sub=0, 0x7F + 0x01 -> sum=0x80, ovf=1.
  - sub=1, 0x80 - 0x01 -> sum=0x7F, ovf=1.
- Busy rejection: start 0x01+0x01, then pulse start with 0xAA+0x55 at cycle 3 -> exactly one done, sum=0x02. A start accepted after busy falls yields 0xFF.
- Reset mid-run: start 0x35+0x4A, deassert rst_n at cycle 4 for 2 cycles -> busy=0, done=0, sum=0 immediately on assert, and no done afterwards. The next start of 0x35+0x4A still gives 0x7F.
- Exhaustive check: all 2^17 (op_a, op_b, cin) combinations for add and all 2^16 (op_a, op_b) for sub against a reference model. Also check done is a single-cycle pulse and sum is stable between operations.
